// File: rtl/ssp_unpack.sv
//------------------------------------------------------------------------------
// Module   : ssp_unpack
// Function : word-to-byte-stream unpacker with valid/ready handshake on both
//            sides; MSB first by default, LSB first with SSP_UNPACK_LSB_FIRST_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ssp_unpack #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 4,
  parameter int WORD_W    = BYTE_W * NUM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [WORD_W-1:0] din,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_last,
  output logic              busy
);

  localparam int              CNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dout_valid_q, dout_valid_d;

  logic              load;
  logic              fire;

  // The current byte always sits at the emitting end of the shift register.
`ifdef SSP_UNPACK_LSB_FIRST_EN
  assign dout = sreg_q[BYTE_W-1:0];
`else
  assign dout = sreg_q[WORD_W-1 -: BYTE_W];
`endif

  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_valid_q & (cnt_q == LAST_CNT);
  assign busy       = (state_q == ST_SEND);
  assign din_ready  = ~rst & ((state_q == ST_IDLE) | (dout_valid_q & dout_ready & dout_last));
  assign load       = din_valid & din_ready;
  assign fire       = dout_valid_q & dout_ready;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    dout_valid_d = dout_valid_q;
    if (load) begin
      // A load wins over the final-byte retire, giving back-to-back words.
      state_d      = ST_SEND;
      sreg_d       = din;
      cnt_d        = '0;
      dout_valid_d = 1'b1;
    end else if (fire) begin
      if (dout_last) begin
        state_d      = ST_IDLE;
        dout_valid_d = 1'b0;
      end else begin
`ifdef SSP_UNPACK_LSB_FIRST_EN
        sreg_d = {{BYTE_W{1'b0}}, sreg_q[WORD_W-1:BYTE_W]};
`else
        sreg_d = {sreg_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
`endif
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssp_unpack.sv
// Bench for ssp_unpack: vector table plus hand sequences, checked against a
// byte scoreboard filled when words are accepted.
`default_nettype none

module tb_ssp_unpack;

  localparam int BW = 8;
  localparam int NB = 4;

  logic          clk;
  logic          rst;
  logic          din_valid;
  logic          din_ready;
  logic [31:0]   din;
  logic          dout_valid;
  logic          dout_ready;
  logic [7:0]    dout;
  logic          dout_last;
  logic          busy;

  ssp_unpack #(.BYTE_W(BW), .NUM_BYTES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    int          stall;
    logic [7:0]  first_b;
    logic [7:0]  last_b;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vecs[4];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         acc;
  logic [7:0] seen_last;

  function automatic logic [7:0] byte_at(input logic [31:0] w, input int i);
`ifdef SSP_UNPACK_LSB_FIRST_EN
    return w[8*i +: 8];
`else
    return w[8*(NB-1-i) +: 8];
`endif
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs against the scoreboard, then advance past the edge.
  task automatic step();
    exp_t e;
    #1;
    acc = din_valid && din_ready;
    if (!rst) begin
      chk1("din_ready", din_ready, (exp_q.size() == 0) || (dout_ready && exp_q.size() == 1));
      chk1("dout_valid", dout_valid, exp_q.size() != 0);
      chk1("busy", busy, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk8("dout", dout, exp_q[0].b);
        chk1("dout_last", dout_last, exp_q[0].l);
        if (dout_ready) begin
          seen_last = exp_q[0].b;
          void'(exp_q.pop_front());
        end
      end else begin
        chk1("dout_last_idle", dout_last, 1'b0);
      end
      if (acc) begin
        for (int i = 0; i < NB; i++) begin
          e.b = byte_at(din, i);
          e.l = (i == NB - 1);
          exp_q.push_back(e);
        end
      end
    end else begin
      chk1("din_ready_in_rst", din_ready, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk1("drain_timeout", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    logic [31:0] words[2];
    int          idx;
    int          valid_cnt;

`ifdef SSP_UNPACK_LSB_FIRST_EN
    vecs[0] = '{32'h940F5124, 0, 8'h24, 8'h94};
    vecs[1] = '{32'h11223344, 3, 8'h44, 8'h11};
    vecs[2] = '{32'hDEADBEEF, 1, 8'hEF, 8'hDE};
    vecs[3] = '{32'h00FF00A5, 0, 8'hA5, 8'h00};
`else
    vecs[0] = '{32'h940F5124, 0, 8'h94, 8'h24};
    vecs[1] = '{32'h11223344, 3, 8'h11, 8'h44};
    vecs[2] = '{32'hDEADBEEF, 1, 8'hDE, 8'hEF};
    vecs[3] = '{32'h00FF00A5, 0, 8'h00, 8'hA5};
`endif

    rst        = 1'b1;
    din_valid  = 1'b0;
    din        = '0;
    dout_ready = 1'b0;
    seen_last  = '0;

    // Reset state, with din_valid raised to confirm din_ready stays low.
    step();
    din_valid = 1'b1;
    step();
    chk1("rst_dout_valid", dout_valid, 1'b0);
    chk8("rst_dout", dout, 8'h00);
    chk1("rst_dout_last", dout_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_din_ready", din_ready, 1'b0);
    din_valid = 1'b0;
    rst       = 1'b0;
    step();

    // Table-driven single words, some with a stall on the first byte.
    foreach (vecs[k]) begin
      din        = vecs[k].word;
      din_valid  = 1'b1;
      dout_ready = (vecs[k].stall == 0);
      step();
      din_valid = 1'b0;
      chk8("first_byte", dout, vecs[k].first_b);
      for (int s = 0; s < vecs[k].stall; s++) step();
      if (vecs[k].stall > 0) chk8("stall_hold", dout, vecs[k].first_b);
      dout_ready = 1'b1;
      drain(10);
      chk8("last_byte", seen_last, vecs[k].last_b);
      step();
      chk1("idle_after_word", dout_valid, 1'b0);
      chk8("dout_hold_idle", dout, vecs[k].last_b);
    end

    // Back-to-back words: eight contiguous valid cycles, no bubble.
    words[0]   = 32'h940F5124;
    words[1]   = 32'h67F3A5C3;
    idx        = 0;
    valid_cnt  = 0;
    din        = words[0];
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (acc) begin
        idx++;
        if (idx < 2) din = words[idx];
        else din_valid = 1'b0;
      end
      if (dout_valid) valid_cnt++;
    end
    chk8("b2b_valid_cycles", 8'(valid_cnt), 8'd8);
    chk1("b2b_drained", exp_q.size() == 0, 1'b1);

    // Reset pulsed mid-word discards the remainder.
    din       = 32'h940F5124;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    chk8("pre_rst_byte", dout, byte_at(32'h940F5124, 1));
    dout_ready = 1'b0;
    rst        = 1'b1;
    step();
    exp_q.delete();
    chk1("midrst_dout_valid", dout_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    rst        = 1'b0;
    dout_ready = 1'b1;
    step();
    din       = 32'hDEADBEEF;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    drain(10);
    chk8("post_rst_last", seen_last, byte_at(32'hDEADBEEF, NB - 1));

    // Word offered while stalled mid-word must not be captured.
    din       = 32'hA1B2C3D4;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    dout_ready = 1'b0;
    din        = 32'hFFFFFFFF;
    din_valid  = 1'b1;
    for (int s = 0; s < 3; s++) step();
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    drain(10);
    chk8("stall_ignore_last", seen_last, byte_at(32'hA1B2C3D4, NB - 1));
    step();
    step();
    chk1("stall_ignore_idle", dout_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
